// File: rtl/cla_share_arbiter.sv
// Round-robin arbiter sharing one external combinational adder between NUM_REQ clients.
// Two-stage pipeline: S1 registers the adder operands, S2 registers the sum with its owner tag.
module cla_share_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_a_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_b_i,
  input  logic [NUM_REQ-1:0]              req_cin_i,
  output logic [ADDR_WIDTH-1:0]           add_a_o,
  output logic [ADDR_WIDTH-1:0]           add_b_o,
  output logic                            add_cin_o,
  input  logic [ADDR_WIDTH:0]             add_sum_i,
  output logic                            rsp_valid_o,
  input  logic                            rsp_ready_i,
  output logic [ID_W-1:0]                 rsp_id_o,
  output logic [ADDR_WIDTH:0]             rsp_sum_o,
  output logic [1:0]                      inflight_o
);

  logic                  v1_q, v1_d;
  logic [ID_W-1:0]       id1_q, id1_d;
  logic [ADDR_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic                  cin_q, cin_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
  logic [ADDR_WIDTH:0]   rsp_sum_q, rsp_sum_d;

  logic                  adv1, adv2, accept, found;
  logic [ID_W-1:0]       winner;
  logic [ID_W:0]         scan_idx;

  assign adv2   = ~rsp_valid_q | rsp_ready_i;
  assign adv1   = ~v1_q | adv2;
  assign accept = adv1 & (|req_valid_i) & ~rst;

  // Scan upward from ptr_q modulo NUM_REQ; first valid client wins.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (scan_idx >= (ID_W+1)'(NUM_REQ)) scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
      if (!found && req_valid_i[scan_idx[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = scan_idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (accept) req_ready_o[winner] = 1'b1;
  end

  always_comb begin
    v1_d        = v1_q;
    id1_d       = id1_q;
    a_d         = a_q;
    b_d         = b_q;
    cin_d       = cin_q;
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    if (accept) begin
      v1_d  = 1'b1;
      id1_d = winner;
      a_d   = req_a_i[winner*ADDR_WIDTH +: ADDR_WIDTH];
      b_d   = req_b_i[winner*ADDR_WIDTH +: ADDR_WIDTH];
      cin_d = req_cin_i[winner];
      ptr_d = (winner == ID_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
    end else if (adv1) begin
      v1_d = 1'b0;
    end
    if (adv2) begin
      rsp_valid_d = v1_q;
      rsp_id_d    = id1_q;
      rsp_sum_d   = add_sum_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q        <= 1'b0;
      id1_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
    end else begin
      v1_q        <= v1_d;
      id1_q       <= id1_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin_q       <= cin_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
    end
  end

  assign add_a_o     = a_q;
  assign add_b_o     = b_q;
  assign add_cin_o   = cin_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_sum_o   = rsp_sum_q;
  assign inflight_o  = {1'b0, v1_q} + {1'b0, rsp_valid_q};

endmodule
